uart_rx_byte: RTL and testbench

UART receiver front end for the serial command path. Samples the raw Uart_Rx pin and recovers 8N1 bytes using oversampling. Presents each byte as a held 8-bit value with a one-cycle valid strobe; that value is the byte consumed by the float-table/UART response path. Also flags framing errors so the upstream link can be diagnosed from LEDs.

---
 rtl/uart_rx_byte.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with oversampled 2-of-3 majority bit decisions.
// Raw rx is synchronised (2 flops), start bits are found on a falling edge of the
// synchronised line, and every bit is decided from three mid-bit samples.
// Optional feature macro UART_RX_PARITY_EN adds an even-parity bit (PARITY state)
// and a sticky parity_err output.
module uart_rx_byte #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int S_W   = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0]   S_SMP_A  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0]   S_SMP_B  = S_W'(OVERSAMPLE / 2);
  localparam logic [S_W-1:0]   S_SMP_C  = S_W'(OVERSAMPLE / 2 + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_meta_d;
  logic               rx_s_q, rx_s_d;
  logic               rx_prev_q, rx_prev_d;
  logic [2:0]         fill_q, fill_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         samp_q, samp_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               data_valid_q, data_valid_d;
  logic               frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_d;
  logic               parity_err_q, parity_err_d;
  logic               par_ok;
`endif

  logic tick;
  logic wrap;
  logic decide;
  logic maj;
  logic fall;

  // fill_q marks when rx_prev holds a real line sample after reset; without it the
  // reset value 1 of the synchroniser would fake a falling edge on a low line.
  assign tick   = (state_q != ST_IDLE) && (div_q == DIV_LAST);
  assign wrap   = tick && (s_q == S_LAST);
  assign decide = tick && (s_q == S_SMP_C);
  assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign fall   = fill_q[2] && rx_prev_q && !rx_s_q;
`ifdef UART_RX_PARITY_EN
  assign par_ok = ~^{shift_q, par_q};
`endif

  // Next-state, counters, sampling and output updates.
  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    rx_prev_d    = rx_s_q;
    fill_d       = {fill_q[1:0], 1'b1};
    div_d        = div_q;
    s_d          = s_q;
    bit_d        = bit_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif

    if (state_q == ST_IDLE) begin
      div_d = '0;
      s_d   = '0;
    end else if (tick) begin
      div_d = '0;
      s_d   = (s_q == S_LAST) ? '0 : s_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (tick && (s_q == S_SMP_A)) samp_d[0] = rx_s_q;
    if (tick && (s_q == S_SMP_B)) samp_d[1] = rx_s_q;

    case (state_q)
      ST_IDLE: begin
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (decide) shift_d = {maj, shift_q[7:1]};
        if (wrap) begin
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (decide) par_d = maj;
        if (wrap) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (decide) begin
          state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
          if (!par_ok) begin
            parity_err_d = 1'b1;
            if (!maj) frame_err_d = 1'b1;
          end else if (maj) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
`else
          if (maj) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            frame_err_d  = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      fill_q       <= '0;
      state_q      <= ST_IDLE;
      div_q        <= '0;
      s_q          <= '0;
      bit_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      fill_q       <= fill_d;
      state_q      <= state_d;
      div_q        <= div_d;
      s_q          <= s_d;
      bit_q        <= bit_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Sample and shift registers; always fully rewritten before use, so no reset.
  always_ff @(posedge sys_clk) begin
    samp_q  <= samp_d;
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte: directed and random frames against a frame-level model.
module tb_uart_rx_byte;

  localparam int CLK_FREQ   = 3200000;
  localparam int BAUD       = 100000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT        = OVERSAMPLE * (CLK_FREQ / (BAUD * OVERSAMPLE));

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rx      = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;

  logic [7:0] got_data[$];
  int         got_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  logic       exp_fe   = 1'b0;
  logic       exp_pe   = 1'b0;
  bit         dv_prev   = 1'b0;
  bit         dv_double = 1'b0;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .rx(rx),
    .data(data),
    .data_valid(data_valid),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Record every data_valid pulse and flag any pulse longer than one cycle.
  always @(negedge sys_clk) begin
    if (data_valid === 1'b1) begin
      got_data.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (dv_prev && (data_valid === 1'b1)) dv_double = 1'b1;
    dv_prev = (data_valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: a frame updates data only with a good stop (and parity).
  function automatic void model_frame(input logic [7:0] b, input logic stop, input logic par_bad);
`ifdef UART_RX_PARITY_EN
    if (par_bad) begin
      exp_pe = 1'b1;
      if (!stop) exp_fe = 1'b1;
      return;
    end
`endif
    if (par_bad) return;
    if (stop) begin
      exp_q.push_back(b);
      exp_data = b;
      exp_fe   = 1'b0;
      exp_pe   = 1'b0;
    end else begin
      exp_fe = 1'b1;
    end
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_bit(input logic v, input int gl_off, input bit chk_busy);
    for (int k = 0; k < BIT; k++) begin
      rx = (k == gl_off) ? ~v : v;
      @(negedge sys_clk);
      if (chk_busy && k == 8) chk("busy_in_frame", busy, 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_bad,
                            input int gl_bit, input bit chk_busy);
    start_cyc = cyc;
    drive_bit(1'b0, (gl_bit == 0) ? 18 : -1, chk_busy);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (gl_bit == i + 1) ? 18 : -1, chk_busy);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_bad, -1, chk_busy);
`endif
    drive_bit(stop, -1, chk_busy);
    model_frame(b, stop, par_bad);
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_count"}, got_data.size(), exp_q.size());
    for (int i = 0; i < got_data.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, got_data[i], exp_q[i]);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_frame_err"}, frame_err, exp_fe);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_parity_err"}, parity_err, exp_pe);
`endif
    chk({tag, "_busy_idle"}, busy, 0);
    got_data.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int lat;
    logic [7:0] rb;
    logic rs;
    int gap;

    // Reset state
    sys_rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", data_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    sys_rst = 1'b0;
    idle(10);

    // Single frame, latency and busy
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1);
    idle(20);
    lat = (got_cyc.size() > 0) ? got_cyc[0] - start_cyc : -1;
    chk("a5_latency_window", (lat >= 300 && lat <= 316), 1);
    check_frames("a5");

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 1'b0, -1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, -1, 1'b0);
    idle(20);
    check_frames("b2b");

    // Bad stop bit, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
    idle(20);
    check_frames("badstop");
    send_frame(8'h12, 1'b1, 1'b0, -1, 1'b0);
    idle(20);
    check_frames("recover");

    // Short low glitch on idle line
    rx = 1'b0;
    repeat (10) @(negedge sys_clk);
    rx = 1'b1;
    chk("glitch_busy", busy, 1);
    idle(40);
    check_frames("glitch");

    // One-clock high glitch in the middle of data bit 3
    send_frame(8'h55, 1'b1, 1'b0, 4, 1'b0);
    idle(20);
    check_frames("midglitch");

    // Break: line held low for 12 bit periods
    rx = 1'b0;
    repeat (12 * BIT) @(negedge sys_clk);
    exp_fe = 1'b1;
    check_frames("break");
    idle(40);
    chk("break_fe_held", frame_err, 1);

    // Reset in the middle of data bit 4 of 8'h0F
    drive_bit(1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, -1, 1'b0);
    rx = 1'b0;
    repeat (10) @(negedge sys_clk);
    chk("rst_mid_busy_pre", busy, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_mid_data", data, 8'h00);
    chk("rst_mid_valid", data_valid, 0);
    chk("rst_mid_frame_err", frame_err, 0);
    chk("rst_mid_busy", busy, 0);
    exp_data = 8'h00;
    exp_fe   = 1'b0;
    exp_pe   = 1'b0;
    repeat (BIT - 11) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, -1, 1'b0);
    drive_bit(1'b1, -1, 1'b0);
    idle(20);
    check_frames("rst_tail");
    send_frame(8'h7E, 1'b1, 1'b0, -1, 1'b0);
    idle(20);
    check_frames("after_rst");

    // Random frames with random gaps and occasional bad stop bits
    for (int n = 0; n < 10; n++) begin
      rb  = 8'($urandom);
      rs  = ($urandom_range(3) != 0);
      gap = $urandom_range(24);
      if (!rs && gap < 3) gap = 3;
      send_frame(rb, rs, 1'b0, -1, 1'b0);
      idle(gap);
    end
    idle(20);
    check_frames("random");

`ifdef UART_RX_PARITY_EN
    // Even parity: correct and corrupted parity bit
    send_frame(8'h07, 1'b1, 1'b0, -1, 1'b0);
    idle(20);
    check_frames("par_good");
    send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0);
    idle(20);
    check_frames("par_bad");
`endif

    chk("valid_single_cycle", dv_double, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
